// File: rtl/run_length_coder.sv
// run_length_coder
//   Turns run-mode results from the mode-decision stage into variable-length
//   code segments, one segment at most per clock. A run of length Runcnt is
//   coded as a series of single '1' bits, each covering 2^J pixels. J comes
//   from the adaptive RUNindex, which moves up on every full 2^J chunk and
//   down after a run that another pixel interrupted. The run is closed by a
//   terminating segment, or by no segment when an end-of-line run has
//   nothing left over.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high; clears all state
//   en         : input strobe, one pixel-result per cycle
//   mode       : 0 regular, 1 in run, 2 run ended by EOL, 3 run interrupted
//   Runcnt     : run length for modes 2 and 3 (0..1023)
//   ready      : high while IDLE, i.e. a new run can be accepted
//   code_valid : code/len hold one segment this cycle
//   code       : segment bits, right-aligned, MSB emitted first
//   len        : segment length in bits (1..16)
//   done       : one-cycle pulse when the current run is fully coded
//   run_index  : RUNindex used by the terminating segment (valid with done)
//   err        : sticky, a run start arrived while a run was still in progress
//   fsm_state  : current FSM state, for observation only
//
// Handshake: a run is accepted on a rising edge where ready=1, en=1 and
// mode is 2 or 3. ready is not back-pressure on en: en with mode 2/3 while
// ready=0 is dropped and raises err; en with mode 0/1 is always ignored.
// Output qualifiers: code/len are meaningful only with code_valid=1 and
// run_index only with done=1; otherwise they read as zero.
module run_length_coder (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [9:0]  Runcnt,
  output logic        ready,
  output logic        code_valid,
  output logic [15:0] code,
  output logic [4:0]  len,
  output logic        done,
  output logic [4:0]  run_index,
  output logic        err,
  output logic [0:0]  fsm_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] MODE_INTERRUPT = 2'd3;

  logic [0:0]  state;
  logic [4:0]  run_idx;
  logic [9:0]  cnt;
  logic [1:0]  mode_r;

  logic [3:0]  j_cur;
  logic [16:0] rm;
  logic        chunk_fits;
  logic        run_start;

  // J as a function of RUNindex.
  function automatic logic [3:0] j_of(input logic [4:0] idx);
    logic [3:0] j;
    if (idx < 5'd4)       j = 4'd0;
    else if (idx < 5'd8)  j = 4'd1;
    else if (idx < 5'd12) j = 4'd2;
    else if (idx < 5'd16) j = 4'd3;
    else if (idx < 5'd18) j = 4'd4;
    else if (idx < 5'd20) j = 4'd5;
    else if (idx < 5'd22) j = 4'd6;
    else if (idx < 5'd24) j = 4'd7;
    else                  j = 4'(idx - 5'd16);
    return j;
  endfunction

  assign j_cur      = j_of(run_idx);
  assign rm         = 17'd1 << j_cur;
  // 17-bit compare: for large J, rm exceeds every possible cnt.
  assign chunk_fits = ({7'd0, cnt} >= rm);
  assign run_start  = en && mode[1];

  assign ready     = (state == S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      run_idx    <= 5'd0;
      cnt        <= 10'd0;
      mode_r     <= 2'd0;
      code_valid <= 1'b0;
      code       <= 16'd0;
      len        <= 5'd0;
      done       <= 1'b0;
      run_index  <= 5'd0;
      err        <= 1'b0;
    end else begin
      // Output registers default to the idle/zero pattern each cycle.
      code_valid <= 1'b0;
      code       <= 16'd0;
      len        <= 5'd0;
      done       <= 1'b0;
      run_index  <= 5'd0;

      case (state)
        S_IDLE: begin
          if (run_start) begin
            cnt    <= Runcnt;
            mode_r <= mode;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          if (run_start) begin
            err <= 1'b1;
          end
          if (chunk_fits) begin
            // A whole 2^J chunk: one '1' bit. rm <= cnt <= 1023 here, so
            // the low 10 bits of rm hold its full value.
            code_valid <= 1'b1;
            code       <= 16'd1;
            len        <= 5'd1;
            cnt        <= cnt - rm[9:0];
            if (run_idx != 5'd31) begin
              run_idx <= run_idx + 5'd1;
            end
          end else begin
            done      <= 1'b1;
            run_index <= run_idx;
            state     <= S_IDLE;
            if (mode_r == MODE_INTERRUPT) begin
              // '0' followed by the J-bit remainder. cnt < 2^J, so the
              // remainder is cnt itself and the leading zero comes for free.
              code_valid <= 1'b1;
              code       <= {6'd0, cnt};
              len        <= {1'b0, j_cur} + 5'd1;
              if (run_idx != 5'd0) begin
                run_idx <= run_idx - 5'd1;
              end
            end else if (cnt != 10'd0) begin
              // End-of-line with a partial chunk left: a single '1' bit.
              code_valid <= 1'b1;
              code       <= 16'd1;
              len        <= 5'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_length_coder.sv
module tb_run_length_coder;

  localparam int W = 28; // {code_valid, code[15:0], len[4:0], done, run_index[4:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic [9:0]  Runcnt;
  logic        ready;
  logic        code_valid;
  logic [15:0] code;
  logic [4:0]  len;
  logic        done;
  logic [4:0]  run_index;
  logic        err;
  logic [0:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           m_idx;
  bit           m_err;
  int           j_tab[32] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3,
                              4, 4, 5, 5, 6, 6, 7, 7, 8, 9, 10, 11, 12, 13, 14, 15};

  run_length_coder dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .Runcnt     (Runcnt),
    .ready      (ready),
    .code_valid (code_valid),
    .code       (code),
    .len        (len),
    .done       (done),
    .run_index  (run_index),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs();
    return {code_valid, code, len, done, run_index};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    assert (act === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Expands one run into the per-cycle output sequence it must produce.
  task automatic model_run(input logic [1:0] md, input int cnt);
    int c;
    int j;
    int rm;
    bit fin;
    c   = cnt;
    fin = 1'b0;
    while (!fin) begin
      j  = j_tab[m_idx];
      rm = 1 << j;
      if (c >= rm) begin
        exp_q.push_back({1'b1, 16'd1, 5'd1, 1'b0, 5'd0});
        c = c - rm;
        if (m_idx < 31) m_idx++;
      end else begin
        if (md == 2'd3) begin
          exp_q.push_back({1'b1, 16'(c), 5'(j + 1), 1'b1, 5'(m_idx)});
          if (m_idx > 0) m_idx--;
        end else if (c > 0) begin
          exp_q.push_back({1'b1, 16'd1, 5'd1, 1'b1, 5'(m_idx)});
        end else begin
          exp_q.push_back({1'b0, 16'd0, 5'd0, 1'b1, 5'(m_idx)});
        end
        fin = 1'b1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; leaves at the negedge of the done cycle so the next
  // run can be offered right away.
  task automatic run_one(input logic [1:0] md, input int cnt, input bit inject);
    logic [W-1:0] e;
    bit first;
    check("ready_before_run", ready, 1);
    en     = 1'b1;
    mode   = md;
    Runcnt = 10'(cnt);
    model_run(md, cnt);
    @(negedge clk);
    check("ready_busy", ready, 0);
    check("quiet_after_accept", obs(), 0);
    if (inject) begin
      // A second run start while busy: must be dropped and flag err.
      en     = 1'b1;
      mode   = 2'($urandom_range(2, 3));
      Runcnt = 10'($urandom_range(0, 1023));
      m_err  = 1'b1;
    end else begin
      en = 1'b0;
    end
    first = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      en = 1'b0;
      check(first ? "first_segment" : "segment", obs(), e);
      first = 1'b0;
    end
    check("ready_after_done", ready, 1);
    check("err_flag", err, m_err);
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      en     = 1'($urandom_range(0, 1));
      mode   = 2'($urandom_range(0, 1));
      Runcnt = 10'($urandom_range(0, 1023));
      @(negedge clk);
      check("idle_quiet", obs(), 0);
      check("idle_ready", ready, 1);
    end
    en = 1'b0;
  endtask

  // Asserts reset away from the clock edge and checks it acts immediately.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    check("reset_outputs", obs(), 0);
    check("reset_ready", ready, 1);
    check("reset_err", err, 0);
    m_idx = 0;
    m_err = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    mode   = 2'd0;
    Runcnt = 10'd0;
    m_idx  = 0;
    m_err  = 1'b0;
    #1;
    check("reset_outputs", obs(), 0);
    check("reset_ready", ready, 1);
    check("reset_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Interrupted zero-length run at RUNindex 0: code 0, len 1, done.
    run_one(2'd3, 0, 1'b0);
    // End-of-line run of 5: five '1' bits, done on the fifth.
    run_one(2'd2, 5, 1'b0);

    // End-of-line run of 4 from RUNindex 0, then interrupted run of 3.
    apply_reset();
    run_one(2'd2, 4, 1'b0);
    run_one(2'd3, 3, 1'b0);

    // Regular / in-run strobes in IDLE are ignored and leave RUNindex alone.
    idle_noise(5);
    run_one(2'd3, 2, 1'b0);

    // Run start while busy: err goes sticky, original run is unaffected.
    run_one(2'd2, 300, 1'b1);
    run_one(2'd3, 7, 1'b0);

    // Reset in the middle of a long run.
    en     = 1'b1;
    mode   = 2'd2;
    Runcnt = 10'd1000;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    apply_reset();
    idle_noise(2);
    run_one(2'd2, 1, 1'b0);

    // Large runs push RUNindex high, then randomized traffic.
    run_one(2'd2, 1023, 1'b0);
    run_one(2'd2, 1023, 1'b0);
    for (int i = 0; i < 40; i++) begin
      int c;
      if ($urandom_range(0, 3) == 0) idle_noise($urandom_range(1, 3));
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 20);
      run_one(2'($urandom_range(2, 3)), c, ($urandom_range(0, 9) == 0));
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
